// File: rtl/sdram_arbiter.sv
// Two-master round-robin front end for the single-port SDRAM controller.
// Latches the winning request, strobes the controller once and returns the read word.
module sdram_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int ADDR_W         = 25
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_valid,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   input  logic [3:0]        m0_wstrb,
   output logic              m0_ready,
   output logic [31:0]       m0_rdata,
   input  logic              m1_valid,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   input  logic [3:0]        m1_wstrb,
   output logic              m1_ready,
   output logic [31:0]       m1_rdata,
   output logic              mem_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wmask,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_done,
   input  logic              mem_init,
   input  logic              mem_busy,
   output logic              timeout_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [3:0]        wstrb;
   } req_t;

   localparam int             CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W:0] TMO_LIM = (CNT_W+1)'(TIMEOUT_CYCLES - 1);

   state_t           state, state_nxt;
   req_t             lat, req_sel;
   logic             gnt, gnt_sel, rr_last;
   logic             grant_en, finish, tmo;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W:0]   cnt_inc;
   logic [31:0]      rd_cap;

   assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
   assign req_sel = gnt_sel ? {m1_addr, m1_wdata, m1_wstrb} : {m0_addr, m0_wdata, m0_wstrb};
   // Writes and forced completions return zero to the master.
   assign rd_cap  = (mem_done && lat.wstrb == 4'h0) ? mem_rdata : 32'h0;

   assign mem_valid = (state == ISSUE);
   assign mem_addr  = lat.addr;
   assign mem_wdata = lat.wdata;
   assign mem_wmask = lat.wstrb;
   assign m0_ready  = (state == RESP) && !gnt;
   assign m1_ready  = (state == RESP) &&  gnt;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_en  = 1'b0;
      gnt_sel   = 1'b0;
      finish    = 1'b0;
      tmo       = 1'b0;
      case (state)
         IDLE: begin
            if (mem_init && !mem_busy && (m0_valid || m1_valid)) begin
               grant_en  = 1'b1;
               gnt_sel   = (m0_valid && m1_valid) ? !rr_last : m1_valid;
               state_nxt = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (mem_done) begin
               finish    = 1'b1;
               state_nxt = RESP;
            end else if (cnt_inc >= TMO_LIM) begin
               finish    = 1'b1;
               tmo       = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gnt         <= 1'b0;
         rr_last     <= 1'b1;
         lat         <= '0;
         cnt         <= '0;
         timeout_err <= 1'b0;
         m0_rdata    <= 32'h0;
         m1_rdata    <= 32'h0;
      end else begin
         if (grant_en) begin
            gnt     <= gnt_sel;
            rr_last <= gnt_sel;
            lat     <= req_sel;
         end
         if (state == ISSUE)
            cnt <= '0;
         else if (state == WAIT && !finish)
            cnt <= cnt_inc[CNT_W-1:0];
         if (tmo)
            timeout_err <= 1'b1;
         if (finish) begin
            if (gnt) m1_rdata <= rd_cap;
            else     m0_rdata <= rd_cap;
         end
      end
   end

endmodule
